// File: rtl/teller_dispatcher.sv
// Bank queue sequencer: issues tickets, counts waiting customers and
// calls the oldest ticket to a round-robin selected open teller.
module teller_dispatcher #(
  parameter int N_TELLERS   = 3,
  parameter int CNT_W       = 4,
  parameter int MAX_WAIT    = 15,
  parameter int TICKET_W    = 7,
  parameter int TICKET_MOD  = 100,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [N_TELLERS-1:0] teller_en,
  input  logic [N_TELLERS-1:0] teller_req,
  output logic [N_TELLERS-1:0] grant,
  output logic                 call_valid,
  output logic [1:0]           call_teller,
  output logic [TICKET_W-1:0]  call_ticket,
  output logic [TICKET_W-1:0]  next_ticket,
  output logic [CNT_W-1:0]     waiting,
  output logic                 q_empty,
  output logic                 q_full
);

  localparam int TMR_W = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic {
    IDLE,
    ANNOUNCE
  } state_t;

  state_t                 state, d_state;
  logic [N_TELLERS-1:0]   pending, d_pending;
  logic [N_TELLERS-1:0]   d_grant;
  logic [1:0]             rr_ptr, d_rr_ptr;
  logic [TMR_W-1:0]       timer, d_timer;
  logic                   d_call_valid;
  logic [1:0]             d_call_teller;
  logic [TICKET_W-1:0]    d_call_ticket;
  logic [TICKET_W-1:0]    d_next_ticket;
  logic [CNT_W-1:0]       d_waiting;

  logic [N_TELLERS-1:0]   eff;
  logic [1:0]             sel;
  logic                   found;
  logic                   fire;
  logic                   accept;
  logic [TICKET_W:0]      nt_x, w_x, oldest;
  int                     idx;

  assign q_empty = (waiting == '0);
  assign q_full  = (waiting == CNT_W'(MAX_WAIT));

  always_comb begin
    eff   = (pending | teller_req) & teller_en;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_TELLERS; k++) begin
      idx = (int'(rr_ptr) + k) % N_TELLERS;
      if (!found && eff[idx]) begin
        found = 1'b1;
        sel   = 2'(idx);
      end
    end

    fire   = (state == IDLE) && !q_empty && found;
    accept = arrive && (!q_full || fire);

    // oldest waiting ticket, modulo the display wrap
    nt_x = {1'b0, next_ticket};
    w_x  = (TICKET_W+1)'(waiting);
    if (nt_x >= w_x)
      oldest = nt_x - w_x;
    else
      oldest = nt_x + (TICKET_W+1)'(TICKET_MOD) - w_x;

    d_state       = state;
    d_grant       = '0;
    d_call_valid  = call_valid;
    d_call_teller = call_teller;
    d_call_ticket = call_ticket;
    d_rr_ptr      = rr_ptr;
    d_timer       = timer;
    d_next_ticket = next_ticket;
    d_waiting     = waiting;
    d_pending     = (pending | (teller_req & teller_en)) & teller_en;

    if (accept) begin
      if (next_ticket == TICKET_W'(TICKET_MOD - 1))
        d_next_ticket = '0;
      else
        d_next_ticket = next_ticket + 1'b1;
    end

    unique case ({accept, fire})
      2'b10:   d_waiting = waiting + 1'b1;
      2'b01:   d_waiting = waiting - 1'b1;
      default: d_waiting = waiting;
    endcase

    unique case (state)
      IDLE: begin
        if (fire) begin
          d_grant        = N_TELLERS'(1) << sel;
          d_pending[sel] = 1'b0;
          d_call_valid   = 1'b1;
          d_call_teller  = sel;
          d_call_ticket  = oldest[TICKET_W-1:0];
          d_rr_ptr       = (sel == 2'(N_TELLERS - 1)) ? 2'd0 : sel + 2'd1;
          d_timer        = TMR_W'(HOLD_CYCLES - 1);
          d_state        = ANNOUNCE;
        end
      end
      ANNOUNCE: begin
        if (timer == '0) begin
          d_state      = IDLE;
          d_call_valid = 1'b0;
        end else begin
          d_timer = timer - 1'b1;
        end
      end
      default: d_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      call_valid  <= 1'b0;
      call_teller <= '0;
      call_ticket <= '0;
      next_ticket <= '0;
      waiting     <= '0;
      pending     <= '0;
      rr_ptr      <= '0;
      timer       <= '0;
    end else begin
      state       <= d_state;
      grant       <= d_grant;
      call_valid  <= d_call_valid;
      call_teller <= d_call_teller;
      call_ticket <= d_call_ticket;
      next_ticket <= d_next_ticket;
      waiting     <= d_waiting;
      pending     <= d_pending;
      rr_ptr      <= d_rr_ptr;
      timer       <= d_timer;
    end
  end

endmodule

// File: tb/tb_teller_dispatcher.sv
// Scoreboard bench for teller_dispatcher: stimulus pushes expected
// calls, a negedge monitor pops and compares on every grant.
module tb_teller_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       arrive;
  logic [2:0] teller_en;
  logic [2:0] teller_req;
  logic [2:0] grant;
  logic       call_valid;
  logic [1:0] call_teller;
  logic [6:0] call_ticket;
  logic [6:0] next_ticket;
  logic [3:0] waiting;
  logic       q_empty;
  logic       q_full;

  teller_dispatcher dut (
    .clk         (clk),
    .reset       (reset),
    .arrive      (arrive),
    .teller_en   (teller_en),
    .teller_req  (teller_req),
    .grant       (grant),
    .call_valid  (call_valid),
    .call_teller (call_teller),
    .call_ticket (call_ticket),
    .next_ticket (next_ticket),
    .waiting     (waiting),
    .q_empty     (q_empty),
    .q_full      (q_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] g;
    logic [1:0] t;
    logic [6:0] tk;
  } exp_t;

  exp_t exp_q[$];
  int   gtimes[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   run    = 0;
  bit   abort  = 0;
  bit   cv_d   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // monitor: compares each grant against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (grant !== 3'b000) begin
      gtimes.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_grant: got grant=%b expected none", grant);
      end else begin
        e = exp_q.pop_front();
        chk("grant", int'(grant), int'(e.g));
        chk("call_teller", int'(call_teller), int'(e.t));
        chk("call_ticket", int'(call_ticket), int'(e.tk));
        chk("call_valid_at_grant", int'(call_valid), 1);
      end
    end
    if (reset) begin
      abort = 1;
      run   = 0;
    end else if (call_valid) begin
      run++;
    end else begin
      if (cv_d && !abort) chk("hold_len", run, 8);
      run   = 0;
      abort = 0;
    end
    cv_d = call_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] g, input logic [1:0] t,
                      input logic [6:0] tk);
    exp_t e;
    e.g  = g;
    e.t  = t;
    e.tk = tk;
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic arrivals(input int n);
    arrive = 1'b1;
    repeat (n) tick;
    arrive = 1'b0;
  endtask

  task automatic req(input logic [2:0] r);
    teller_req = r;
    tick;
    teller_req = '0;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (call_valid && k < 40) begin
      tick;
      k++;
    end
    if (call_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: call_valid stuck high, expected low");
    end
    tick;
  endtask

  initial begin
    arrive     = 1'b0;
    teller_en  = 3'b111;
    teller_req = 3'b000;
    do_reset;

    chk("rst_waiting", int'(waiting), 0);
    chk("rst_next", int'(next_ticket), 0);
    chk("rst_empty", int'(q_empty), 1);
    chk("rst_full", int'(q_full), 0);
    chk("rst_cv", int'(call_valid), 0);
    chk("rst_ticket", int'(call_ticket), 0);

    // basic call
    arrivals(3);
    chk("t1_next", int'(next_ticket), 3);
    chk("t1_wait", int'(waiting), 3);
    chk("t1_empty", int'(q_empty), 0);
    push(3'b010, 2'd1, 7'd0);
    req(3'b010);
    chk("t1_wait_after", int'(waiting), 2);
    wait_idle;

    // three simultaneous requests, round-robin
    do_reset;
    arrivals(5);
    gtimes.delete();
    push(3'b001, 2'd0, 7'd0);
    push(3'b010, 2'd1, 7'd1);
    push(3'b100, 2'd2, 7'd2);
    req(3'b111);
    repeat (30) tick;
    chk("t2_wait", int'(waiting), 2);
    chk("t2_ngrants", gtimes.size(), 3);
    if (gtimes.size() == 3) begin
      chk("t2_gap01", gtimes[1] - gtimes[0], 9);
      chk("t2_gap12", gtimes[2] - gtimes[1], 9);
    end
    wait_idle;

    // full queue
    do_reset;
    arrivals(16);
    chk("t3_wait", int'(waiting), 15);
    chk("t3_full", int'(q_full), 1);
    chk("t3_next", int'(next_ticket), 15);
    push(3'b001, 2'd0, 7'd0);
    arrive = 1'b1;
    req(3'b001);
    arrive = 1'b0;
    chk("t3_next_coinc", int'(next_ticket), 16);
    chk("t3_wait_coinc", int'(waiting), 15);
    wait_idle;

    // closed teller request is ignored
    do_reset;
    arrivals(2);
    teller_en = 3'b101;
    req(3'b010);
    repeat (3) tick;
    chk("t4_no_call", int'(call_valid), 0);
    push(3'b100, 2'd2, 7'd0);
    req(3'b100);
    wait_idle;
    teller_en = 3'b111;
    repeat (12) tick;
    chk("t4_no_stale", int'(call_valid), 0);
    chk("t4_wait", int'(waiting), 1);

    // ticket wrap
    do_reset;
    for (int i = 0; i < 97; i++) begin
      arrivals(1);
      push(3'b001, 2'd0, 7'(i));
      req(3'b001);
      wait_idle;
    end
    arrivals(1);
    chk("t5_next98", int'(next_ticket), 98);
    chk("t5_wait1", int'(waiting), 1);
    arrivals(3);
    chk("t5_next_wrap", int'(next_ticket), 1);
    chk("t5_wait4", int'(waiting), 4);
    push(3'b001, 2'd0, 7'd97);
    req(3'b001);
    wait_idle;
    push(3'b001, 2'd0, 7'd98);
    req(3'b001);
    wait_idle;
    push(3'b001, 2'd0, 7'd99);
    req(3'b001);
    wait_idle;
    push(3'b001, 2'd0, 7'd0);
    req(3'b001);
    wait_idle;
    chk("t5_empty", int'(q_empty), 1);

    // reset mid-announce
    do_reset;
    arrivals(3);
    push(3'b001, 2'd0, 7'd0);
    req(3'b001);
    req(3'b110);
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t6_cv", int'(call_valid), 0);
    chk("t6_wait", int'(waiting), 0);
    chk("t6_next", int'(next_ticket), 0);
    chk("t6_grant", int'(grant), 0);
    arrivals(1);
    repeat (15) tick;
    chk("t6_no_stale", int'(call_valid), 0);
    chk("t6_wait1", int'(waiting), 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/teller_dispatcher.md
Name: teller_dispatcher

Overview:
Sequences the bank queue. It issues ticket numbers to arriving customers, tracks the waiting count, and calls the next ticket to a free, open teller. When several tellers request at once, it picks one round-robin. It sits between the debounced arrive/teller-request inputs and the seven-segment/ROM path, which consumes waiting, call_ticket and call_teller.

Parameters:
N_TELLERS, 3, number of teller windows (2..4)
CNT_W, 4, width of waiting counter
MAX_WAIT, 15, queue capacity (must be ≤ 2^CNT_W-1)
TICKET_W, 7, ticket number width
TICKET_MOD, 100, ticket wraps MOD-1 -> 0 (two-digit display)
HOLD_CYCLES, 8, cycles an announcement is held (≥1)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high
arrive  in  1  one-cycle pulse, customer takes ticket (already debounced)
teller_en  in  N_TELLERS  level, teller window open (switch)
teller_req  in  N_TELLERS  one-cycle pulse per bit, teller ready for next customer
grant  out  N_TELLERS  one-hot, one-cycle pulse to the selected teller
call_valid  out  1  announcement active
call_teller  out  2  index of called teller
call_ticket  out  TICKET_W  ticket being called
next_ticket  out  TICKET_W  number the next arrival receives
waiting  out  CNT_W  customers issued but not yet called
q_empty  out  1  waiting==0 (combinational from register)
q_full  out  1  waiting==MAX_WAIT

Behaviour:
- Reset (synchronous, high): state=IDLE; grant=0; call_valid=0; call_teller=0; call_ticket=0; next_ticket=0; waiting=0; pending=0; rr_ptr=0; timer=0. Resulting flags: q_empty=1, q_full=0.
- Arrival, in any state:
  - If arrive and waiting<MAX_WAIT (or a call decrements waiting this same cycle): next_ticket++, wrapping TICKET_MOD-1 -> 0.
  - If arrive while full with no simultaneous call: the arrival is dropped and next_ticket is unchanged.
- pending[i]:
  - Set by teller_req[i] & teller_en[i].
  - Cleared when grant[i] fires or teller_en[i] goes low.
  - A request from a closed teller is ignored.
- Effective request vector: eff = (pending | teller_req) & teller_en.
- FSM IDLE:
  - If waiting>0 and eff≠0: select the first set bit of eff scanning from rr_ptr upward, with wrap.
  - At that edge:
    - grant[sel]=1 for one cycle; pending[sel] cleared.
    - call_valid=1; call_teller=sel.
    - call_ticket=next_ticket-waiting (mod TICKET_MOD), i.e. the oldest waiting ticket.
    - waiting-- (net unchanged if an arrival is accepted the same cycle).
    - rr_ptr=(sel+1) mod N_TELLERS; timer=HOLD_CYCLES-1; go to ANNOUNCE.
  - Latency: teller_req high in cycle 0 -> grant/call_valid high in cycle 1.
- FSM ANNOUNCE:
  - grant=0; call_valid, call_teller and call_ticket are held.
  - If timer==0: go to IDLE and clear call_valid. Else timer--.
  - call_valid is therefore high for exactly HOLD_CYCLES cycles.
  - Requests arriving now are latched in pending and served later. No grant is issued during ANNOUNCE.
  - call_ticket keeps its last value after call_valid falls.
- Requests with waiting==0 stay pending and are served as soon as an arrival makes waiting>0, at the earliest one cycle after the arrival edge.
- Reset in mid-ANNOUNCE: all state returns to reset values next edge; pending requests are lost.
- Arithmetic: the ticket subtraction is done modulo TICKET_MOD. waiting never underflows or exceeds MAX_WAIT.

Test Plan:
- Reset, then 3 arrive pulses -> next_ticket=3, waiting=3, q_empty=0. teller_en=3'b111, teller_req=3'b010 -> cycle+1: grant=3'b010, call_teller=1, call_ticket=0, waiting=2, call_valid high for 8 cycles.
- waiting=5, teller_req=3'b111 in one cycle -> grants to teller 0, then 1, then 2, each 9 cycles apart (8 hold + 1 IDLE); call_tickets 0,1,2; waiting=2.
- 16 arrivals from empty -> waiting=15, q_full=1, next_ticket=15; 16th arrival dropped. Arrival coincident with a grant while full -> accepted, next_ticket=16, waiting stays 15.
- teller_en=3'b101, teller_req=3'b010 with waiting=2 -> no grant, pending stays 0. Req on teller 2 -> grant=3'b100.
- next_ticket=98, waiting=1 (oldest=97), 3 arrivals -> next_ticket=1; successive calls give call_ticket 97,98,99,0.
- Reset asserted 3 cycles into ANNOUNCE -> next cycle call_valid=0, waiting=0, next_ticket=0, state IDLE; stale pending is not granted.
